// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - lane state encoding and width helpers for obstacle_ctrl
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARN   = 2'd1,
    ACTIVE = 2'd2,
    COOL   = 2'd3
  } lane_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Counter only needs to reach max(ARM,HOLD)-1; never narrower than one bit.
  function automatic int tick_cnt_w(input int arm_ticks, input int hold_ticks);
    int m;
    m = (arm_ticks > hold_ticks) ? arm_ticks : hold_ticks;
    return (m > 1) ? clog2(m) : 1;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - enable-gated blink tick divider
module blink_prescaler
  import obstacle_pkg::*;
#(
  parameter int DIV   = 25000000,
  parameter int CNT_W = 28
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Enable,
  output logic Tick,
  output logic Blink
);

  if (DIV < 2 || (CNT_W < 31 && ((DIV - 1) >> CNT_W) != 0)) begin : g_param_err
    $error("blink_prescaler: DIV must be >= 2 and fit in CNT_W bits");
  end

  logic [CNT_W-1:0] count_q, count_d;
  logic             blink_q, blink_d;
  logic             wrap;

  assign wrap = Enable && (count_q == CNT_W'(DIV - 1));

  always_comb begin
    count_d = count_q;
    blink_d = blink_q;
    if (wrap) begin
      count_d = '0;
      blink_d = ~blink_q;
    end else if (Enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
      blink_q <= 1'b0;
    end else begin
      count_q <= count_d;
      blink_q <= blink_d;
    end
  end

  assign Tick  = wrap;
  assign Blink = blink_q;

endmodule

// File: rtl/obstacle_ctrl.sv
// rtl/obstacle_ctrl.sv - per-lane obstacle arming, warning blink, hazard hold and hit counting
module obstacle_ctrl
  import obstacle_pkg::*;
#(
  parameter int LANES      = 7,
  parameter int DIV        = 25000000,
  parameter int CNT_W      = 28,
  parameter int ARM_TICKS  = 2,
  parameter int HOLD_TICKS = 4,
  parameter int HITW       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [LANES-1:0] Player,
  output logic [LANES-1:0] Obstacle,
  output logic             Blink,
  output logic             Tick,
  output logic             Hit,
  output logic [HITW-1:0]  Hit_count
);

  if (LANES < 2 || DIV < 2 || ARM_TICKS < 1 || HOLD_TICKS < 1) begin : g_param_err
    $error("obstacle_ctrl: illegal parameter combination");
  end

  localparam int TCW = tick_cnt_w(ARM_TICKS, HOLD_TICKS);

  logic [LANES-1:0] sync1_q, player_s_q;
  logic             player_valid;
  logic [LANES-1:0] target, arm, coll;
  logic             hit_q, hit_d;
  logic [HITW-1:0]  hit_count_q, hit_count_d;

  blink_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_prescaler (
    .Clk   (Clk),
    .Reset (Reset),
    .Enable(Enable),
    .Tick  (Tick),
    .Blink (Blink)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q    <= '0;
      player_s_q <= '0;
    end else begin
      sync1_q    <= Player;
      player_s_q <= sync1_q;
    end
  end

  // Valid only when exactly one lane is selected; target is the lane ahead, wrapping.
  assign player_valid = (player_s_q != '0) && ((player_s_q & (player_s_q - LANES'(1))) == '0);
  assign target       = {player_s_q[LANES-2:0], player_s_q[LANES-1]};
  assign arm          = (Tick && player_valid) ? target : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_state_e    state_q, state_d;
    logic [TCW-1:0] cnt_q, cnt_d;
    logic           obs_q;

    assign coll[i] = Enable && player_valid && player_s_q[i] && (state_q == ACTIVE);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        IDLE: begin
          if (arm[i]) begin
            state_d = WARN;
            cnt_d   = '0;
          end
        end
        WARN: begin
          if (Tick) begin
            if (cnt_q == TCW'(ARM_TICKS - 1)) begin
              state_d = ACTIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + TCW'(1);
            end
          end
        end
        ACTIVE: begin
          if (coll[i]) begin
            state_d = COOL;
          end else if (Tick) begin
            if (cnt_q == TCW'(HOLD_TICKS - 1)) state_d = COOL;
            else cnt_d = cnt_q + TCW'(1);
          end
        end
        COOL: begin
          if (Tick) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        obs_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        obs_q   <= (state_q == ACTIVE) || ((state_q == WARN) && Blink);
      end
    end

    assign Obstacle[i] = obs_q;
  end

  always_comb begin
    hit_d       = |coll;
    hit_count_d = hit_count_q;
    if (hit_d && (hit_count_q != '1)) hit_count_d = hit_count_q + HITW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  assign Hit       = hit_q;
  assign Hit_count = hit_count_q;

endmodule

// File: tb/tb_obstacle_ctrl.sv
// tb/tb_obstacle_ctrl.sv - randomized self-checking bench for obstacle_ctrl against a countdown lane model
module tb_obstacle_ctrl;

  localparam int LANES = 7;
  localparam int DIV   = 4;
  localparam int CNT_W = 2;
  localparam int ARM   = 2;
  localparam int HOLD  = 3;
  localparam int HITW  = 8;
  localparam int P_IDLE = 0, P_WARN = 1, P_ACTIVE = 2, P_COOL = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [LANES-1:0] player = '0;
  logic [LANES-1:0] obstacle;
  logic             blink, tick, hit;
  logic [HITW-1:0]  hit_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  obstacle_ctrl #(
    .LANES(LANES), .DIV(DIV), .CNT_W(CNT_W),
    .ARM_TICKS(ARM), .HOLD_TICKS(HOLD), .HITW(HITW)
  ) dut (
    .Clk(clk), .Reset(rst), .Enable(en), .Player(player),
    .Obstacle(obstacle), .Blink(blink), .Tick(tick), .Hit(hit), .Hit_count(hit_count)
  );

  // Reference model: prescaler as an integer count, lanes as phase + ticks remaining.
  int               m_cnt, m_cnt_n;
  logic             m_blink, m_blink_n;
  logic [LANES-1:0] m_s1, m_s2;
  int               m_phase [LANES];
  int               m_phase_n [LANES];
  int               m_left [LANES];
  int               m_left_n [LANES];
  logic [LANES-1:0] m_obs, m_obs_n;
  logic             m_hit, m_hit_n;
  logic [7:0]       m_hits, m_hits_n;
  logic             m_tick;

  assign m_tick = en && (m_cnt == DIV - 1);

  always_comb begin
    int  tgt;
    bit  valid;
    bit  coll;
    tgt       = -1;
    valid     = ($countones(m_s2) == 1);
    coll      = 1'b0;
    m_cnt_n   = m_cnt;
    m_blink_n = m_blink;
    m_hit_n   = 1'b0;
    m_hits_n  = m_hits;
    m_obs_n   = '0;
    for (int k = 0; k < LANES; k++) if (m_s2[k]) tgt = (k + 1) % LANES;
    if (en) begin
      if (m_tick) begin
        m_cnt_n   = 0;
        m_blink_n = !m_blink;
      end else begin
        m_cnt_n = m_cnt + 1;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      m_phase_n[i] = m_phase[i];
      m_left_n[i]  = m_left[i];
      m_obs_n[i]   = (m_phase[i] == P_WARN) ? m_blink : (m_phase[i] == P_ACTIVE);
      coll = en && valid && m_s2[i] && (m_phase[i] == P_ACTIVE);
      if (coll) begin
        m_hit_n = 1'b1;
        if (m_hits != 8'hFF) m_hits_n = m_hits + 8'd1;
      end
      if (m_phase[i] == P_IDLE) begin
        if (m_tick && valid && tgt == i) begin
          m_phase_n[i] = P_WARN;
          m_left_n[i]  = ARM;
        end
      end else if (m_phase[i] == P_WARN) begin
        if (m_tick) begin
          m_left_n[i] = m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_phase_n[i] = P_ACTIVE;
            m_left_n[i]  = HOLD;
          end
        end
      end else if (m_phase[i] == P_ACTIVE) begin
        if (coll) m_phase_n[i] = P_COOL;
        else if (m_tick) begin
          m_left_n[i] = m_left[i] - 1;
          if (m_left[i] == 1) m_phase_n[i] = P_COOL;
        end
      end else begin
        if (m_tick) m_phase_n[i] = P_IDLE;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_blink <= 1'b0;
      m_s1    <= '0;
      m_s2    <= '0;
      m_obs   <= '0;
      m_hit   <= 1'b0;
      m_hits  <= '0;
      for (int i = 0; i < LANES; i++) begin
        m_phase[i] <= P_IDLE;
        m_left[i]  <= 0;
      end
    end else begin
      m_cnt   <= m_cnt_n;
      m_blink <= m_blink_n;
      m_s1    <= player;
      m_s2    <= m_s1;
      m_obs   <= m_obs_n;
      m_hit   <= m_hit_n;
      m_hits  <= m_hits_n;
      m_phase <= m_phase_n;
      m_left  <= m_left_n;
    end
  end

  logic [17:0] dut_vec, mdl_vec;
  assign dut_vec = {obstacle, blink, tick, hit, hit_count};
  assign mdl_vec = {m_obs, m_blink, m_tick, m_hit, m_hits};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; player = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (dut_vec !== 18'h0) begin
      errors++; $display("FAIL reset_hold: got %h want 0", dut_vec);
    end
    rst = 1'b0; en = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec !== 18'h0) begin
      errors++; $display("FAIL reset_release: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_idle();
    int   ticks, toggles;
    logic prev;
    do_reset();
    ticks = 0; toggles = 0; prev = blink;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL idle_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
      if (tick) ticks++;
      if (blink !== prev) toggles++;
      prev = blink;
    end
    checks++;
    if (ticks != 10) begin errors++; $display("FAIL idle_tick_count: got %0d want 10", ticks); end
    checks++;
    if (toggles != 10) begin errors++; $display("FAIL idle_blink_toggles: got %0d want 10", toggles); end
  endtask

  task automatic test_lane(input logic [LANES-1:0] pos, input logic [LANES-1:0] lane_mask, input string nm);
    int seen, stray, hits;
    do_reset();
    player = pos;
    seen = 0; stray = 0; hits = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL %s_model cyc %0d: got %h want %h", nm, c, dut_vec, mdl_vec);
      end
      if ((obstacle & lane_mask) != '0) seen++;
      if ((obstacle & ~lane_mask) != '0) stray++;
      if (hit) hits++;
    end
    checks++;
    if (seen == 0) begin errors++; $display("FAIL %s_seen: got 0 cycles want >0", nm); end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL %s_stray: got %0d want 0", nm, stray); end
    checks++;
    if (hits != 0 || hit_count !== 8'd0) begin
      errors++; $display("FAIL %s_nohit: got pulses %0d count %0d want 0 0", nm, hits, hit_count);
    end
  endtask

  task automatic test_hit();
    int n, pulses, after_bad;
    bit last_hit;
    do_reset();
    player = 7'b0000001;
    n = 0;
    while (m_phase[1] != P_ACTIVE && n < 100) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL hit_arm_model cyc %0d: got %h want %h", n, dut_vec, mdl_vec);
      end
      n++;
    end
    checks++;
    if (m_phase[1] != P_ACTIVE) begin errors++; $display("FAIL hit_arm_timeout: got %0d cycles want <100", n); end
    player = 7'b0000010;
    pulses = 0; after_bad = 0; last_hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL hit_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
      if (last_hit && obstacle[1] !== 1'b0) after_bad++;
      last_hit = hit;
      if (hit) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL hit_pulses: got %0d want 1", pulses); end
    checks++;
    if (hit_count !== 8'd1) begin errors++; $display("FAIL hit_count: got %0d want 1", hit_count); end
    checks++;
    if (after_bad != 0) begin errors++; $display("FAIL hit_obstacle_clear: got %0d want 0", after_bad); end
  endtask

  task automatic test_invalid();
    int pulses, late_obs;
    logic [HITW-1:0] hc0;
    hc0 = hit_count;
    player = 7'b0000101;
    pulses = 0; late_obs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL invalid_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
      if (hit) pulses++;
      if (c >= 40 && obstacle != '0) late_obs++;
    end
    checks++;
    if (pulses != 0 || hit_count !== hc0) begin
      errors++; $display("FAIL invalid_nohit: got pulses %0d count %0d want 0 %0d", pulses, hit_count, hc0);
    end
    checks++;
    if (late_obs != 0) begin errors++; $display("FAIL invalid_noarm: got %0d want 0", late_obs); end
  endtask

  task automatic test_freeze();
    int n, bad;
    logic b0;
    logic [LANES-1:0] o0;
    player = 7'b0000001;
    n = 0;
    while (m_phase[1] != P_WARN && n < 100) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL freeze_arm_model cyc %0d: got %h want %h", n, dut_vec, mdl_vec);
      end
      n++;
    end
    checks++;
    if (m_phase[1] != P_WARN) begin errors++; $display("FAIL freeze_arm_timeout: got %0d cycles want <100", n); end
    en = 1'b0;
    @(negedge clk);
    b0 = blink; o0 = obstacle;
    bad = 0;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL freeze_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
      if (blink !== b0 || obstacle !== o0 || tick !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL freeze_hold: got %0d changed cycles want 0", bad); end
    en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL freeze_resume_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    player = 7'b0000001;
    n = 0;
    while (!(m_phase[1] == P_ACTIVE && obstacle[1] === 1'b1) && n < 100) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL rstmid_arm_model cyc %0d: got %h want %h", n, dut_vec, mdl_vec);
      end
      n++;
    end
    checks++;
    if (obstacle[1] !== 1'b1) begin errors++; $display("FAIL rstmid_active: got %b want 1", obstacle[1]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec !== 18'h0) begin errors++; $display("FAIL rstmid_async_clear: got %h want 0", dut_vec); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL rstmid_after_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        if ($urandom_range(3) != 0) player = LANES'(1) << $urandom_range(LANES - 1);
        else player = LANES'($urandom);
        hold = $urandom_range(12, 1);
      end
      hold--;
      en = ($urandom_range(9) != 0);
      @(negedge clk);
      checks++;
      if (dut_vec !== mdl_vec) begin
        errors++; $display("FAIL random_model cyc %0d: got %h want %h", c, dut_vec, mdl_vec);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_saturate();
    int extra, n;
    logic [HITW-1:0] prev_hc;
    bit got;
    extra = 0;
    en = 1'b1;
    for (int it = 0; it < 300 && extra < 3; it++) begin
      player = 7'b0000001;
      n = 0;
      while (m_phase[1] != P_ACTIVE && n < 200) begin
        @(negedge clk);
        checks++;
        if (dut_vec !== mdl_vec) begin
          errors++; $display("FAIL sat_arm_model it %0d: got %h want %h", it, dut_vec, mdl_vec);
        end
        n++;
      end
      player = 7'b0000010;
      got = 1'b0;
      prev_hc = hit_count;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        checks++;
        if (dut_vec !== mdl_vec) begin
          errors++; $display("FAIL sat_hit_model it %0d: got %h want %h", it, dut_vec, mdl_vec);
        end
        if (hit) begin
          got = 1'b1;
          if (prev_hc == 8'hFF && hit_count == 8'hFF) extra++;
        end
        prev_hc = hit_count;
      end
    end
    checks++;
    if (extra != 3) begin errors++; $display("FAIL sat_pulses_at_max: got %0d want 3", extra); end
    checks++;
    if (hit_count !== 8'hFF) begin errors++; $display("FAIL sat_count: got %0d want 255", hit_count); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_lane(7'b0000001, 7'b0000010, "arm_lane1");
    test_lane(7'b1000000, 7'b0000001, "wrap_lane0");
    test_hit();
    test_invalid();
    test_freeze();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obstacle_ctrl.md
Name: obstacle_ctrl

Overview:
Parametrised obstacle generator for the lane game. It tracks a one-hot player position across LANES lanes. It arms an obstacle in the lane ahead of the player, shows it blinking as a warning, then holds it solid as a hazard. It detects player/obstacle collisions and counts hits. It sits between the player-position logic and the LED/segment drivers, and replaces the fixed 3-lane obstacle logic and its free-running blink timer.

Parameters:
LANES, 7, number of lanes; width of Player and Obstacle
DIV, 25000000, Clk cycles per blink tick (one half-period of Blink)
CNT_W, 28, prescaler counter width; must satisfy 2^CNT_W >= DIV
ARM_TICKS, 2, ticks an obstacle spends blinking (WARN) before it turns solid
HOLD_TICKS, 4, ticks an obstacle stays solid (ACTIVE)
HITW, 8, width of Hit_count

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
Enable  in  1  1 = run; 0 = freeze prescaler, lane FSMs and hit detection
Player  in  LANES  player position, one-hot, asynchronous to Clk (switch/button derived)
Obstacle  out  LANES  per-lane obstacle drive
Blink  out  1  square wave, toggles on every tick
Tick  out  1  one-cycle pulse when the prescaler wraps
Hit  out  1  one-cycle pulse on a collision
Hit_count  out  HITW  saturating collision count

Behaviour:
- One clock: Clk. Reset is asynchronous and active-high.
- On reset:
  - Obstacle=0, Blink=0, Tick=0, Hit=0, Hit_count=0.
  - Prescaler=0, all lanes IDLE, Player synchroniser cleared.
- Player input path:
  - Two-flop synchroniser, so 2 cycles of latency to the internal Player_s.
  - Player_s is valid only when exactly one bit is set.
  - Zero or multiple bits set means invalid: no arming and no hit detection. Existing lanes keep running.
- Prescaler:
  - Counts 0..DIV-1 while Enable=1.
  - When count==DIV-1: count wraps to 0, Tick=1 for that cycle, Blink toggles.
  - While Enable=0: count, Blink and Tick are held, and Tick is forced to 0.
- Target lane:
  - Player_s in lane p targets lane t=(p+1) mod LANES.
  - The last lane wraps to lane 0.
- Lane FSM, one per lane; states IDLE, WARN, ACTIVE, COOL. A per-lane tick counter is sized for max(ARM_TICKS,HOLD_TICKS).
  - IDLE: Obstacle[i]=0. On Tick, if Player_s is valid and t==i, go to WARN with counter=0.
  - WARN: Obstacle[i]=Blink. Counter increments on each Tick. After ARM_TICKS ticks, go to ACTIVE with counter=0.
  - ACTIVE: Obstacle[i]=1. After HOLD_TICKS ticks, go to COOL. A collision also moves the lane to COOL on the next cycle.
  - COOL: Obstacle[i]=0. On the next Tick, go to IDLE. A lane cannot re-arm on the same Tick that it leaves COOL.
- Arming limits: at most one lane arms per Tick, namely lane t. A lane that is not IDLE ignores arming.
- Collision: checked every cycle (not only on Tick) while Enable=1.
  - Condition: a lane is ACTIVE and Player_s[i]=1.
  - Result: Hit=1 for one cycle and Hit_count increments, saturating at 2^HITW-1.
  - Each ACTIVE episode produces at most one hit.
  - A lane in WARN is harmless.
- Simultaneous events:
  - If a collision and the HOLD expiry occur in the same cycle, the hit still counts and the lane goes to COOL.
  - If Tick and a collision occur in the same cycle, the collision takes priority.
- Reset asserted mid-operation: all outputs clear immediately, with no completion of episodes in flight.
- Obstacle outputs are registered, one cycle after the state or Blink change.
- Parameter legality: LANES>=2, DIV>=2, ARM_TICKS>=1, HOLD_TICKS>=1. Illegal values are an elaboration error.

Decomposition:
- Package obstacle_pkg holds:
  - lane state encoding: IDLE=2'd0, WARN=2'd1, ACTIVE=2'd2, COOL=2'd3
  - a clog2 helper for the lane tick counter width
- Sub-module blink_prescaler (parameters DIV, CNT_W; ports Clk, Reset, Enable, Tick, Blink). It succeeds the old free-running timer.
- The lane FSMs are a generate loop inside obstacle_ctrl, not a separate module.

Test Plan:
All scenarios use DIV=4, LANES=7, ARM_TICKS=2, HOLD_TICKS=3.
- Reset release, Enable=1, Player=0 -> Tick every 4 cycles, Blink toggles each Tick, Obstacle=0, Hit_count=0.
- Player=7'b0000001 held -> lane 1 arms on the first Tick after the 2-cycle sync. Obstacle[1] follows Blink for 2 ticks, is 1 for 3 ticks, then 0. No Hit.
- Player=7'b1000000 -> the target wraps, so Obstacle[0] runs WARN then ACTIVE.
- Lane 1 ACTIVE, then Player moves to 7'b0000010 -> Hit pulses for exactly 1 cycle and Hit_count=1. Obstacle[1]=0 next cycle. Player held there gives no second hit.
- Player=7'b0000101 (invalid) -> no lane arms, no Hit. Lanes armed earlier finish their sequence normally.
- Enable=0 during WARN for 20 cycles -> Blink, Obstacle and counters frozen. Reset pulse mid-ACTIVE -> all outputs 0 asynchronously. Force Hit_count to 255 and collide -> Hit_count stays 255 while Hit still pulses.
